// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute->memory register stage with a 2-entry skid buffer and branch/jump redirect.
// Results are fully formed at accept time, so the buffer only stores and replays them.
module ex_mem_stage #(
   parameter int XLEN   = 64,
   parameter int RD_W   = 5,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_opcode,
   input  logic [XLEN-1:0]   in_result,
   input  logic [XLEN-1:0]   in_rs1_val,
   input  logic [XLEN-1:0]   in_rs2_val,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_opcode,
   output logic [XLEN-1:0]   out_result,
   output logic [XLEN-1:0]   out_store_data,
   output logic [RD_W-1:0]   out_rd,
   output logic [XLEN-1:0]   out_pc,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic [PERF_W-1:0] redirect_count
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   typedef struct packed {
      logic [7:0]      opcode;
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] store_data;
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] pc;
   } entry_t;
   state_t          state_q, state_n;
   entry_t          main_q, main_n, skid_q, skid_n, new_e;
   logic            ready_q, accept, depart, taken;
   logic            is_store, is_branch, is_jal, is_jalr, is_lui;
   logic [XLEN-1:0] imm12, base_sum, target, lui_val;
   assign is_store  = in_opcode >= 8'd43 && in_opcode <= 8'd46;
   assign is_branch = in_opcode >= 8'd47 && in_opcode <= 8'd52;
   assign is_jal    = in_opcode == 8'd53;
   assign is_jalr   = in_opcode == 8'd54;
   assign is_lui    = in_opcode == 8'd55;
   assign imm12     = {{(XLEN-12){in_imm[11]}}, in_imm[11:0]};
   assign lui_val   = {{(XLEN-32){in_imm[19]}}, in_imm[19:0], 12'h000};
   assign base_sum  = in_rs1_val + imm12;
   assign taken     = is_jal | is_jalr | (is_branch & in_result[0]);
   assign target    = is_jalr ? {base_sum[XLEN-1:1], 1'b0} : in_pc + in_imm;
   assign new_e = '{
      opcode:     in_opcode,
      result:     is_store ? base_sum : (is_jal | is_jalr) ? in_pc + XLEN'(4) : is_lui ? lui_val : in_result,
      store_data: is_store ? in_rs2_val : '0,
      rd:         (is_store | is_branch) ? '0 : in_rd,
      pc:         in_pc
   };
   // flush wins over any same-cycle accept, including its redirect
   assign accept    = in_valid & ready_q & ~flush;
   assign depart    = (state_q != EMPTY) & out_ready;
   assign in_ready  = ready_q;
   assign out_valid = state_q != EMPTY;
   assign out_opcode     = main_q.opcode;
   assign out_result     = main_q.result;
   assign out_store_data = main_q.store_data;
   assign out_rd         = main_q.rd;
   assign out_pc         = main_q.pc;
   always_comb begin
      state_n = state_q;
      main_n  = main_q;
      skid_n  = skid_q;
      case (state_q)
         EMPTY: if (accept) begin
            main_n  = new_e;
            state_n = ONE;
         end
         ONE: if (accept & depart) main_n = new_e;
         else if (accept) begin
            skid_n  = new_e;
            state_n = TWO;
         end else if (depart) state_n = EMPTY;
         TWO: if (depart) begin
            main_n  = skid_q;
            state_n = ONE;
         end
         default: state_n = EMPTY;
      endcase
      if (flush) state_n = EMPTY;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= EMPTY;
         main_q         <= '0;
         skid_q         <= '0;
         ready_q        <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         redirect_count <= '0;
      end else begin
         state_q        <= state_n;
         main_q         <= main_n;
         skid_q         <= skid_n;
         ready_q        <= state_n != TWO;
         redirect_valid <= accept & taken;
         if (accept & taken) begin
            redirect_pc    <= target;
            redirect_count <= redirect_count + PERF_W'(redirect_count != '1);
         end
      end
   end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed stimulus checked against a queue-based model plus literal expectations.
module tb_ex_mem_stage;
   logic        clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 1;
   logic [7:0]  in_opcode = 0;
   logic [63:0] in_result = 0, in_rs1_val = 0, in_rs2_val = 0, in_imm = 0, in_pc = 0;
   logic [4:0]  in_rd = 0;
   logic        in_ready, out_valid, redirect_valid;
   logic [7:0]  out_opcode;
   logic [63:0] out_result, out_store_data, out_pc, redirect_pc;
   logic [4:0]  out_rd;
   logic [2:0]  redirect_count;
   int checks = 0, errors = 0;
   bit go = 0;

   ex_mem_stage #(.XLEN(64), .RD_W(5), .PERF_W(3)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_result(in_result), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_result(out_result), .out_store_data(out_store_data),
      .out_rd(out_rd), .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_count(redirect_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [63:0] res, sd, pc;
      logic [4:0]  rd;
   } ent_t;
   ent_t q[$];
   bit   m_ready = 0, m_rv = 0;
   logic [63:0] m_rpc = 0;
   int   m_cnt = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic ent_t form();
      ent_t e;
      logic [63:0] s12;
      s12 = 64'($signed(in_imm[11:0]));
      e.op = in_opcode; e.pc = in_pc; e.rd = in_rd; e.sd = 0; e.res = in_result;
      if (in_opcode >= 43 && in_opcode <= 46) begin
         e.res = in_rs1_val + s12; e.sd = in_rs2_val; e.rd = 0;
      end else if (in_opcode >= 47 && in_opcode <= 52) e.rd = 0;
      else if (in_opcode == 53 || in_opcode == 54) e.res = in_pc + 4;
      else if (in_opcode == 55) e.res = 64'($signed({in_imm[19:0], 12'h000}));
      return e;
   endfunction

   function automatic bit taken_f();
      return in_opcode == 53 || in_opcode == 54 || (in_opcode >= 47 && in_opcode <= 52 && in_result[0]);
   endfunction

   function automatic logic [63:0] target_f();
      logic [63:0] t;
      t = (in_opcode == 54) ? in_rs1_val + 64'($signed(in_imm[11:0])) : in_pc + in_imm;
      if (in_opcode == 54) t[0] = 1'b0;
      return t;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete(); m_ready = 0; m_rv = 0; m_cnt = 0;
      end else begin
         bit acc, dep;
         dep = q.size() > 0 && out_ready;
         acc = in_valid && m_ready && !flush;
         m_rv = acc && taken_f();
         if (m_rv) begin
            m_rpc = target_f();
            m_cnt = (m_cnt == 7) ? 7 : m_cnt + 1;
         end
         if (flush) q.delete();
         else begin
            if (dep) void'(q.pop_front());
            if (acc) q.push_back(form());
         end
         m_ready = q.size() != 2;
      end
   end

   always @(negedge clk) if (go) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("out_opcode", 64'(out_opcode), 64'(q[0].op));
         chk("out_result", out_result, q[0].res);
         chk("out_store_data", out_store_data, q[0].sd);
         chk("out_rd", 64'(out_rd), 64'(q[0].rd));
         chk("out_pc", out_pc, q[0].pc);
      end
      chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
      if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
      chk("redirect_count", 64'(redirect_count), 64'(m_cnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [63:0] res, rs1, rs2, imm, pc, input logic [4:0] rd);
      in_valid = 1; in_opcode = op; in_result = res; in_rs1_val = rs1;
      in_rs2_val = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
   endtask

   initial begin
      #2 reset = 1;
      #1 go = 1;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_count", 64'(redirect_count), 0);
      @(posedge clk); #1 reset = 0;
      tick();
      chk("ready_after_reset", 64'(in_ready), 1);
      // ADD
      drive(8'd0, 64'h5, 0, 0, 0, 64'h10, 5'd3);
      tick(); in_valid = 0;
      chk("add_valid", 64'(out_valid), 1);
      chk("add_result", out_result, 64'h5);
      chk("add_rd", 64'(out_rd), 3);
      tick();
      // BEQ taken backwards
      drive(8'd47, 64'h1, 0, 0, -64'sd16, 64'h1000, 5'd7);
      tick(); in_valid = 0;
      chk("beq_rv", 64'(redirect_valid), 1);
      chk("beq_rpc", redirect_pc, 64'hFF0);
      chk("beq_rd", 64'(out_rd), 0);
      tick();
      chk("beq_pulse_end", 64'(redirect_valid), 0);
      // JALR
      drive(8'd54, 0, 64'h2003, 0, 64'h4, 64'h80, 5'd1);
      tick(); in_valid = 0;
      chk("jalr_result", out_result, 64'h84);
      chk("jalr_rpc", redirect_pc, 64'h2006);
      chk("jalr_count", 64'(redirect_count), 2);
      tick();
      // SW with address wrap
      drive(8'd45, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAB, 64'h001, 64'h90, 5'd9);
      tick(); in_valid = 0;
      chk("sw_addr", out_result, 64'h0);
      chk("sw_data", out_store_data, 64'hAB);
      chk("sw_rd", 64'(out_rd), 0);
      tick();
      // back-pressure: three pushes, two accepted
      out_ready = 0;
      drive(8'd55, 0, 0, 0, 64'h80000, 64'h200, 5'd4);
      tick();
      drive(8'd1, 64'h22, 0, 0, 0, 64'h204, 5'd5);
      tick();
      drive(8'd53, 0, 0, 0, 64'h100, 64'h400, 5'd2);
      tick();
      chk("full_in_ready", 64'(in_ready), 0);
      chk("lui_result", out_result, 64'hFFFF_FFFF_8000_0000);
      out_ready = 1;
      tick();
      chk("drain_b", out_result, 64'h22);
      tick(); in_valid = 0;
      chk("drain_c", out_result, 64'h404);
      chk("jal_rv", 64'(redirect_valid), 1);
      chk("jal_rpc", redirect_pc, 64'h500);
      tick();
      chk("drained", 64'(out_valid), 0);
      // flush while full with a taken BNE at the input
      out_ready = 0;
      drive(8'd2, 64'h1, 0, 0, 0, 64'h600, 5'd6);
      tick();
      drive(8'd3, 64'h2, 0, 0, 0, 64'h604, 5'd6);
      tick();
      drive(8'd48, 64'h1, 0, 0, 64'h40, 64'h608, 5'd6);
      flush = 1;
      tick(); flush = 0; in_valid = 0;
      chk("flush2_valid", 64'(out_valid), 0);
      chk("flush2_rv", 64'(redirect_valid), 0);
      chk("flush2_count", 64'(redirect_count), 3);
      // flush in ONE while a taken BNE would be accepted
      drive(8'd2, 64'h7, 0, 0, 0, 64'h700, 5'd6);
      tick();
      drive(8'd48, 64'h1, 0, 0, 64'h40, 64'h704, 5'd6);
      flush = 1;
      tick(); flush = 0; in_valid = 0;
      chk("flush1_valid", 64'(out_valid), 0);
      chk("flush1_rv", 64'(redirect_valid), 0);
      chk("flush1_count", 64'(redirect_count), 3);
      chk("flush1_ready", 64'(in_ready), 1);
      // a pulse already registered survives a following flush
      out_ready = 1;
      drive(8'd53, 0, 0, 0, 64'h20, 64'h800, 5'd1);
      tick(); in_valid = 0; flush = 1;
      chk("pre_flush_rv", 64'(redirect_valid), 1);
      chk("pre_flush_count", 64'(redirect_count), 4);
      tick(); flush = 0;
      chk("post_flush_valid", 64'(out_valid), 0);
      // back-to-back taken jumps saturate the counter
      for (int i = 0; i < 6; i++) begin
         drive(8'd53, 0, 0, 0, 64'h8, 64'(i * 4), 5'd1);
         tick();
         chk("b2b_rv", 64'(redirect_valid), 1);
      end
      in_valid = 0;
      chk("sat_count", 64'(redirect_count), 7);
      tick();
      // asynchronous reset with entries buffered
      out_ready = 0;
      drive(8'd0, 64'h11, 0, 0, 0, 64'h900, 5'd2);
      tick();
      drive(8'd0, 64'h12, 0, 0, 0, 64'h904, 5'd2);
      tick(); in_valid = 0;
      #2 reset = 1;
      #1;
      chk("areset_valid", 64'(out_valid), 0);
      chk("areset_count", 64'(redirect_count), 0);
      chk("areset_rv", 64'(redirect_valid), 0);
      tick(); reset = 0;
      tick();
      chk("areset_ready", 64'(in_ready), 1);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
